// File: rtl/mem_access_unit.sv
// Load/store sequencer to a word-wide synchronous memory: aligns addresses, waits READ_LATENCY, extracts/extends loads, RMWs sub-word stores.
// Loads finish in READ_LATENCY+1 cycles, word stores in 2, sub-word stores in READ_LATENCY+2; Busy marks when Req is ignored.
module mem_access_unit #(
    parameter int READ_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WrEn,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Done,
    output logic        AddrErr,
    output logic        Busy,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWr,
    input  logic [31:0] MemRData
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] LAT = READ_LATENCY[2:0];

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic        wr_en_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        err_q;

    logic        misaligned;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [4:0]  sh;
    logic [31:0] load_val;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] merged;

    assign misaligned = (Size == 2'b11) ||
                        (Size == 2'b01 && Addr[0]) ||
                        (Size == 2'b10 && Addr[1:0] != 2'b00);

    assign Busy    = (state != IDLE);
    assign MemWr   = (state == WR);
    assign Done    = (state == DONE);
    assign AddrErr = (state == DONE) && err_q;

    always_comb begin
        sh = {lane_q, 3'b000};
        case (lane_q)
            2'd0:    lane_byte = MemRData[7:0];
            2'd1:    lane_byte = MemRData[15:8];
            2'd2:    lane_byte = MemRData[23:16];
            default: lane_byte = MemRData[31:24];
        endcase
        lane_half = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_val = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_val = MemRData;
        endcase
        // Lane shift is 8*offset; halfword offsets are always 0 or 2 once aligned.
        mask   = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        ins    = ((size_q == 2'b00) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q}) << sh;
        merged = (MemRData & ~mask) | (ins & mask);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            wr_en_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lane_q   <= 2'b00;
            wdata_q  <= 16'h0;
            err_q    <= 1'b0;
            RData    <= 32'h0;
            MemAddr  <= 32'h0;
            MemWData <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        wr_en_q  <= WrEn;
                        size_q   <= Size;
                        signed_q <= Signed;
                        lane_q   <= Addr[1:0];
                        wdata_q  <= WData[15:0];
                        MemAddr  <= {Addr[31:2], 2'b00};
                        cnt      <= LAT;
                        err_q    <= misaligned;
                        if (misaligned) begin
                            state <= DONE;
                        end else if (WrEn && Size == 2'b10) begin
                            MemWData <= WData;
                            state    <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (wr_en_q) begin
                            MemWData <= merged;
                            state    <= WR;
                        end else begin
                            RData <= load_val;
                            state <= DONE;
                        end
                    end
                end
                WR:      state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
